// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path and the transmit tick path.
//   rx_state_t   receiver FSM states
//   DATA_BITS    payload bits per frame
//   log2         ceiling log2, usable in constant expressions
//   acc_width    fractional-accumulator width for a given clock/baud pair
//   acc_inc      accumulator increment that yields Baud*Oversampling carries per second
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } rx_state_t;

   // Smallest r with 2**r >= v, so log2(8) = 3 and log2(217) = 8.
   function automatic int log2(input longint v);
      int r;
      r = 0;
      while ((longint'(1) << r) < v) r = r + 1;
      return r;
   endfunction

   // Eight guard bits beyond the clk/baud ratio keep the rate error far below 2%.
   function automatic int acc_width(input longint clk_hz, input longint baud);
      return log2(clk_hz / baud) + 8;
   endfunction

   // Rounded Baud*Oversampling * 2**acc_w / clk_hz.
   function automatic longint acc_inc(input longint clk_hz, input longint baud,
                                      input longint os, input int acc_w);
      return ((baud * os) * (longint'(1) << acc_w) + clk_hz / 2) / clk_hz;
   endfunction

endpackage

// File: rtl/uart_rx_tick.sv
// uart_rx_tick: free-running fractional accumulator; tick pulses one clk on each carry,
// giving an average tick rate of Baud*Oversampling.
//   clk    in   system clock
//   reset  in   synchronous, active-high; loads the accumulator with Inc
//   tick   out  one-clk pulse per oversampling period
module uart_rx_tick import uart_pkg::*; #(
   parameter int ClkFrequency = 25000000,
   parameter int Baud         = 115200,
   parameter int Oversampling = 8
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam int AccWidth = acc_width(ClkFrequency, Baud);
   localparam logic [AccWidth-1:0] Inc =
      AccWidth'(acc_inc(ClkFrequency, Baud, Oversampling, AccWidth));

   logic [AccWidth-1:0] acc;
   logic [AccWidth:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, Inc};

   always_ff @(posedge clk) begin
      if (reset) begin
         acc  <= Inc;
         tick <= 1'b0;
      end else begin
         acc  <= sum[AccWidth-1:0];
         tick <= sum[AccWidth];
      end
   end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: RS-232 receiver, 8N1 by default, 8E1 when UART_RX_PARITY_EN is defined.
//   clk         in   system clock
//   reset       in   synchronous, active-high; drops any frame in flight without a pulse
//   rxd         in   asynchronous serial line, idle high
//   rx_data     out  last good byte (LSB first on the line), held until the next good frame
//   rx_valid    out  one-clk strobe when rx_data updates
//   rx_busy     out  high from start-bit confirmation until leaving STOP/BREAK
//   frame_err   out  one-clk strobe when the stop bit samples low
//   parity_err  out  one-clk strobe with rx_valid on even-parity mismatch; 0 without UART_RX_PARITY_EN
// Handshake: rx_valid is a strobe with no back-pressure; the consumer captures rx_data in
// the strobe cycle or any later cycle before the next strobe, since rx_data is held.
// Config macro: UART_RX_PARITY_EN adds the PARITY state and the parity_err logic.
module uart_rx import uart_pkg::*; #(
   parameter int ClkFrequency = 25000000,
   parameter int Baud         = 115200,
   parameter int Oversampling = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 rx_busy,
   output logic                 frame_err,
   output logic                 parity_err
);

   localparam int CntWidth = log2(Oversampling);
   localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
   localparam logic [CntWidth-1:0] CntLast = CntWidth'(Oversampling - 1);
   localparam logic [CntWidth-1:0] CntHalf = CntWidth'(Oversampling / 2 - 1);
   localparam logic [2:0]          BitLast = 3'(DATA_BITS - 1);

   logic                 tick;
   logic [1:0]           sync;
   logic [2:0]           samp;
   logic                 filt;
   rx_state_t            state;
   logic [CntWidth-1:0]  count;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] sreg;
`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
`endif

   uart_rx_tick #(
      .ClkFrequency(ClkFrequency),
      .Baud        (Baud),
      .Oversampling(Oversampling)
   ) u_tick (
      .clk  (clk),
      .reset(reset),
      .tick (tick)
   );

   // Synchronizer and tick-rate sample history both reset to the idle level.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync <= 2'b11;
         samp <= 3'b111;
      end else begin
         sync <= {sync[0], rxd};
         if (tick) samp <= {samp[1:0], sync[1]};
      end
   end

   // 2-of-3 majority rejects single-sample glitches.
   assign filt = (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]);

   // START waits half a bit before re-checking, so every later sample lands mid-bit
   // after a full Oversampling count.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         count     <= '0;
         bit_idx   <= '0;
         sreg      <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         rx_busy   <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parity_err <= 1'b0;
`endif
         if (tick) begin
            case (state)
               IDLE: begin
                  count <= '0;
                  if (!filt) state <= START;
               end
               START: begin
                  if (count == CntHalf) begin
                     count <= '0;
                     if (!filt) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        rx_busy <= 1'b1;
                     end else begin
                        state <= IDLE;
                     end
                  end else begin
                     count <= count + CntOne;
                  end
               end
               DATA: begin
                  count <= count + CntOne;
                  if (count == CntLast) begin
                     sreg    <= {filt, sreg[DATA_BITS-1:1]};
                     bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                     if (bit_idx == BitLast) state <= PARITY;
`else
                     if (bit_idx == BitLast) state <= STOP;
`endif
                  end
               end
`ifdef UART_RX_PARITY_EN
               PARITY: begin
                  count <= count + CntOne;
                  if (count == CntLast) begin
                     par_bit <= filt;
                     state   <= STOP;
                  end
               end
`endif
               STOP: begin
                  count <= count + CntOne;
                  if (count == CntLast) begin
                     if (filt) begin
                        rx_data  <= sreg;
                        rx_valid <= 1'b1;
                        rx_busy  <= 1'b0;
                        state    <= IDLE;
`ifdef UART_RX_PARITY_EN
                        // Even parity: data plus parity bit must hold an even number of ones.
                        parity_err <= ^{sreg, par_bit};
`endif
                     end else begin
                        frame_err <= 1'b1;
                        state     <= BREAK;
                     end
                  end
               end
               BREAK: begin
                  if (filt) begin
                     state   <= IDLE;
                     rx_busy <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: bench for uart_rx at 25 MHz / 115200 baud / 8x oversampling.
// Each frame sent queues one expected outcome {parity_err, frame_err, data} with the
// cycle window in which its decision pulse must appear.
`timescale 1ns/1ps
module tb_uart_rx;

   localparam int B = 217;  // clk per bit at 25 MHz / 115200
`ifdef UART_RX_PARITY_EN
   localparam int NB  = 11;
   localparam bit PAR = 1'b1;
`else
   localparam int NB  = 10;
   localparam bit PAR = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       rxd;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       frame_err;
   logic       parity_err;

   uart_rx #(
      .ClkFrequency(25000000),
      .Baud        (115200),
      .Oversampling(8)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .rxd       (rxd),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_busy   (rx_busy),
      .frame_err (frame_err),
      .parity_err(parity_err)
   );

   // ---------------- clock / reset ----------------
   always #20 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #10ms;
      $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [9:0] exp_q[$];  // {parity_err, frame_err, data}
   int         lo_q[$];
   int         hi_q[$];
   logic [7:0] last_data = 8'h00;
   int         n_tests = 0;
   int         n_fail  = 0;
   int         n_valid = 0;
   int         n_ferr  = 0;
   int         n_perr  = 0;
   bit         in_reset = 1'b1;
   bit         busy_forbidden = 1'b0;
   logic [9:0] e;
   int         lo;
   int         hi;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (!in_reset) begin
         if (rx_valid || frame_err) begin
            if (rx_valid)   n_valid++;
            if (frame_err)  n_ferr++;
            if (parity_err) n_perr++;
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL unexpected_pulse: rx_valid=%0b frame_err=%0b with no frame pending (cycle %0d)",
                        rx_valid, frame_err, cyc);
            end else begin
               e  = exp_q.pop_front();
               lo = lo_q.pop_front();
               hi = hi_q.pop_front();
               chk("pulse_kind", {30'd0, rx_valid, frame_err}, {30'd0, !e[8], e[8]});
               chk("parity_err", {31'd0, parity_err}, {31'd0, e[9]});
               chk("pulse_not_early", (cyc >= lo) ? 32'd1 : 32'd0, 32'd1);
               if (rx_valid) last_data = e[7:0];
            end
         end else begin
            chk("parity_err_quiet", {31'd0, parity_err}, 32'd0);
         end
         chk("rx_data", {24'd0, rx_data}, {24'd0, last_data});
         if (busy_forbidden) chk("busy_on_glitch", {31'd0, rx_busy}, 32'd0);
         if (exp_q.size() != 0 && cyc > hi_q[0]) begin
            n_tests++;
            n_fail++;
            $display("FAIL pulse_timeout: no pulse by cycle %0d, required by cycle %0d", cyc, hi_q[0]);
            void'(exp_q.pop_front());
            void'(lo_q.pop_front());
            void'(hi_q.pop_front());
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic v, input int b);
      rxd = v;
      wait_clks(b);
   endtask

   // bad_stop holds the stop position low for 3 bit times, then releases the line high.
   task automatic send_frame(input logic [7:0] d, input int b, input logic pbit, input bit bad_stop);
      int t0;
      t0 = cyc;
      exp_q.push_back({PAR & !bad_stop & (^{d, pbit}), bad_stop, d});
      lo_q.push_back(t0 + (NB - 1) * b);
      hi_q.push_back(t0 + NB * b + b / 2);
      drive_bit(1'b0, b);
      for (int i = 0; i < 8; i++) begin
         rxd = d[i];
         wait_clks(b / 2);
         if (i == 4) chk("busy_mid_frame", {31'd0, rx_busy}, 32'd1);
         wait_clks(b - b / 2);
      end
      if (PAR) drive_bit(pbit, b);
      if (!bad_stop) begin
         drive_bit(1'b1, b);
      end else begin
         rxd = 1'b0;
         wait_clks(2 * b);
         chk("busy_in_break", {31'd0, rx_busy}, 32'd1);
         wait_clks(b);
         rxd = 1'b1;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int         b;
      int         gap;
      logic [7:0] d;
      logic       pb;
      bit         bad;

      reset = 1'b1;
      rxd   = 1'b1;
      wait_clks(5);
      chk("reset_rx_data",    {24'd0, rx_data}, 32'd0);
      chk("reset_rx_valid",   {31'd0, rx_valid}, 32'd0);
      chk("reset_rx_busy",    {31'd0, rx_busy}, 32'd0);
      chk("reset_frame_err",  {31'd0, frame_err}, 32'd0);
      chk("reset_parity_err", {31'd0, parity_err}, 32'd0);
      reset     = 1'b0;
      last_data = 8'h00;
      in_reset  = 1'b0;
      wait_clks(2 * B);

      // single good frame
      send_frame(8'h55, B, 1'b0, 1'b0);
      wait_clks(B);
      chk("data_55", {24'd0, rx_data}, 32'h55);
      chk("busy_after_55", {31'd0, rx_busy}, 32'd0);
      chk("valid_count_1", n_valid, 32'd1);

      // back-to-back, no idle bit between frames
      send_frame(8'h00, B, 1'b0, 1'b0);
      chk("data_00", {24'd0, rx_data}, 32'h00);
      send_frame(8'hFF, B, 1'b0, 1'b0);
      wait_clks(B);
      chk("data_FF", {24'd0, rx_data}, 32'hFF);
      chk("valid_count_3", n_valid, 32'd3);

      // short low glitch must not start a frame
      busy_forbidden = 1'b1;
      rxd = 1'b0;
      wait_clks(24);
      rxd = 1'b1;
      wait_clks(3 * B);
      busy_forbidden = 1'b0;
      chk("valid_count_glitch", n_valid, 32'd3);

      // stop bit held low: frame error, data retained, then recovery
      send_frame(8'hA3, B, 1'b1, 1'b1);
      wait_clks(B);
      chk("data_kept_FF", {24'd0, rx_data}, 32'hFF);
      chk("ferr_count_1", n_ferr, 32'd1);
      chk("busy_after_break", {31'd0, rx_busy}, 32'd0);
      send_frame(8'h3C, B, 1'b0, 1'b0);
      wait_clks(B);
      chk("data_3C", {24'd0, rx_data}, 32'h3C);

      // reset in the middle of the data bits of 0x81
      d = 8'h81;
      drive_bit(1'b0, B);
      for (int i = 0; i < 4; i++) drive_bit(d[i], B);
      chk("busy_before_reset", {31'd0, rx_busy}, 32'd1);
      in_reset = 1'b1;
      reset    = 1'b1;
      rxd      = 1'b1;
      wait_clks(1);
      chk("midreset_rx_data",   {24'd0, rx_data}, 32'd0);
      chk("midreset_rx_valid",  {31'd0, rx_valid}, 32'd0);
      chk("midreset_rx_busy",   {31'd0, rx_busy}, 32'd0);
      chk("midreset_frame_err", {31'd0, frame_err}, 32'd0);
      wait_clks(2);
      reset     = 1'b0;
      last_data = 8'h00;
      exp_q.delete();
      lo_q.delete();
      hi_q.delete();
      in_reset  = 1'b0;
      wait_clks(2 * B);
      chk("valid_count_after_reset", n_valid, 32'd4);
      send_frame(8'h7E, B, 1'b0, 1'b0);
      wait_clks(B);
      chk("data_7E", {24'd0, rx_data}, 32'h7E);

      // +/-2% baud skew
      send_frame(8'hC9, 213, 1'b0, 1'b0);
      wait_clks(B);
      chk("data_C9_fast", {24'd0, rx_data}, 32'hC9);
      send_frame(8'hC9, 221, 1'b0, 1'b0);
      wait_clks(B);
      chk("data_C9_slow", {24'd0, rx_data}, 32'hC9);
      chk("ferr_count_still_1", n_ferr, 32'd1);

`ifdef UART_RX_PARITY_EN
      // 0x07 has three ones: parity bit 0 is wrong, 1 is right
      send_frame(8'h07, B, 1'b0, 1'b0);
      wait_clks(B);
      chk("perr_count_1", n_perr, 32'd1);
      chk("data_07", {24'd0, rx_data}, 32'h07);
      send_frame(8'h07, B, 1'b1, 1'b0);
      wait_clks(B);
      chk("perr_count_still_1", n_perr, 32'd1);
`endif

      // randomized frames
      for (int k = 0; k < 12; k++) begin
         d   = 8'($urandom_range(0, 255));
         b   = $urandom_range(214, 220);
         pb  = 1'($urandom_range(0, 1));
         bad = ($urandom_range(0, 5) == 0);
         send_frame(d, b, pb, bad);
         if (bad)                            gap = B;
         else if ($urandom_range(0, 2) == 0) gap = 0;
         else                                gap = $urandom_range(1, 2 * B);
         if (gap > 0) begin
            rxd = 1'b1;
            wait_clks(gap);
         end
      end

      rxd = 1'b1;
      wait_clks(2 * B);
      chk("all_frames_resolved", exp_q.size(), 32'd0);
      chk("busy_at_end", {31'd0, rx_busy}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
